// File: rtl/score_accumulator_bcd_if.sv
// Hit-detection / score-drawer bus of the score accumulator.
interface score_accumulator_bcd_if #(
  parameter int unsigned NUMBERS = 9,
  parameter int unsigned DIGITS  = 3
);
  logic [NUMBERS-1:0]      SingleHitPulse;
  logic [2:0]              operandHit;
  logic [NUMBERS-1:0][3:0] NumbersToShow;
  logic                    clearScore;
  logic [DIGITS-1:0][3:0]  ScoreToShow;
  logic                    SignToShow;
  logic                    ShowSign;
  logic                    saturated;
  logic                    busy;
  logic                    updated;

  modport master (
    output SingleHitPulse, operandHit, NumbersToShow, clearScore,
    input  ScoreToShow, SignToShow, ShowSign, saturated, busy, updated
  );

  modport slave (
    input  SingleHitPulse, operandHit, NumbersToShow, clearScore,
    output ScoreToShow, SignToShow, ShowSign, saturated, busy, updated
  );
endinterface

// File: rtl/score_accumulator_bcd.sv
// Signed saturating score accumulator with a shift-add-3 BCD readout.
module score_accumulator_bcd #(
  parameter int unsigned NUMBERS   = 9,
  parameter int unsigned DIGITS    = 3,
  parameter int unsigned MAX_SCORE = 999
) (
  input  logic                   clk,
  input  logic                   resetN,
  score_accumulator_bcd_if.slave bus
);
  localparam int unsigned W  = $clog2(MAX_SCORE + 1);
  localparam int unsigned SW = W + 5;
  localparam int unsigned BW = DIGITS * 4;
  localparam int unsigned RW = BW + W;
  localparam int unsigned CW = $clog2(W + 1);

  localparam logic signed [SW-1:0] MAX_S = SW'(MAX_SCORE);
  localparam logic signed [SW-1:0] MIN_S = -MAX_S;

  typedef enum logic [1:0] {S_IDLE, S_PLUS, S_MINUS, S_TIMES} op_state_e;
  typedef enum logic [1:0] {C_IDLE, C_LOAD, C_SHIFT, C_DONE}  conv_state_e;

  op_state_e               op_state_q, op_state_d;
  conv_state_e             conv_state_q, conv_state_d;
  logic signed [SW-1:0]    score_q, score_d;
  logic signed [SW-1:0]    op_res_c, hit_v_c, abs_c;
  logic                    score_chg_c, hit_any_c;
  logic [3:0]              hit_val_c;
  logic                    pending_q, pending_d;
  logic [RW-1:0]           sh_q, sh_d;
  logic [CW-1:0]           iter_q, iter_d;
  logic                    neg_q, neg_d;
  logic [DIGITS-1:0][3:0]  disp_q, disp_d;
  logic                    sign_q, sign_d;
  logic                    show_q, show_d;
  logic                    busy_q, busy_d;
  logic                    upd_q, upd_d;

  // One shift-add-3 iteration over the {bcd, binary} shift register.
  function automatic logic [RW-1:0] dabble_step(input logic [RW-1:0] s);
    logic [RW-1:0] t;
    t = s;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (t[W + 4*d +: 4] >= 4'd5) t[W + 4*d +: 4] = t[W + 4*d +: 4] + 4'd3;
    end
    return {t[RW-2:0], 1'b0};
  endfunction

  // Lowest-index hit tile wins.
  always_comb begin
    hit_any_c = 1'b0;
    hit_val_c = 4'd0;
    for (int i = int'(NUMBERS) - 1; i >= 0; i--) begin
      if (bus.SingleHitPulse[i]) begin
        hit_any_c = 1'b1;
        hit_val_c = bus.NumbersToShow[i];
      end
    end
  end

  assign hit_v_c = $signed({{(SW-4){1'b0}}, hit_val_c});
  assign abs_c   = score_q[SW-1] ? -score_q : score_q;

  // Operator FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) op_state_q <= S_IDLE;
    else         op_state_q <= op_state_d;
  end

  // Operator FSM next state: clear first, then lowest operand bit.
  always_comb begin
    op_state_d = op_state_q;
    if (bus.clearScore)         op_state_d = S_IDLE;
    else if (bus.operandHit[0]) op_state_d = S_PLUS;
    else if (bus.operandHit[1]) op_state_d = S_MINUS;
    else if (bus.operandHit[2]) op_state_d = S_TIMES;
  end

  // Operator FSM output: apply the present operator and clamp.
  always_comb begin
    score_d     = score_q;
    score_chg_c = 1'b0;
    op_res_c    = score_q;
    case (op_state_q)
      S_PLUS:  op_res_c = score_q + hit_v_c;
      S_MINUS: op_res_c = score_q - hit_v_c;
      S_TIMES: op_res_c = score_q * hit_v_c;
      default: op_res_c = score_q;
    endcase
    if (bus.clearScore) begin
      score_d     = '0;
      score_chg_c = 1'b1;
    end else if (hit_any_c && (op_state_q != S_IDLE)) begin
      score_chg_c = 1'b1;
      if (op_res_c > MAX_S)      score_d = MAX_S;
      else if (op_res_c < MIN_S) score_d = MIN_S;
      else                       score_d = op_res_c;
    end
  end

  // Internal score register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) score_q <= '0;
    else         score_q <= score_d;
  end

  // Converter FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) conv_state_q <= C_IDLE;
    else         conv_state_q <= conv_state_d;
  end

  // Converter FSM next state.
  always_comb begin
    conv_state_d = conv_state_q;
    case (conv_state_q)
      C_IDLE:  if (pending_q) conv_state_d = C_LOAD;
      C_LOAD:  conv_state_d = C_SHIFT;
      C_SHIFT: if (iter_q == CW'(W - 1)) conv_state_d = C_DONE;
      C_DONE:  conv_state_d = C_IDLE;
      default: conv_state_d = C_IDLE;
    endcase
  end

  // Converter FSM outputs: snapshot, shift, publish.
  always_comb begin
    pending_d = pending_q;
    sh_d      = sh_q;
    iter_d    = iter_q;
    neg_d     = neg_q;
    disp_d    = disp_q;
    sign_d    = sign_q;
    show_d    = show_q;
    upd_d     = 1'b0;
    busy_d    = (conv_state_d != C_IDLE);
    if (score_chg_c)                             pending_d = 1'b1;
    else if ((conv_state_q == C_IDLE) && pending_q) pending_d = 1'b0;
    case (conv_state_q)
      C_LOAD: begin
        sh_d   = {{BW{1'b0}}, abs_c[W-1:0]};
        neg_d  = score_q[SW-1];
        iter_d = '0;
      end
      C_SHIFT: begin
        sh_d   = dabble_step(sh_q);
        iter_d = iter_q + CW'(1);
      end
      C_DONE: begin
        for (int j = 0; j < int'(DIGITS); j++) begin
          disp_d[j] = sh_q[W + 4*(int'(DIGITS) - 1 - j) +: 4];
        end
        sign_d = neg_q;
        show_d = |sh_q[RW-1:W];
        upd_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Converter datapath and display registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending_q <= 1'b0;
      sh_q      <= '0;
      iter_q    <= '0;
      neg_q     <= 1'b0;
      disp_q    <= '0;
      sign_q    <= 1'b0;
      show_q    <= 1'b0;
      busy_q    <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      sh_q      <= sh_d;
      iter_q    <= iter_d;
      neg_q     <= neg_d;
      disp_q    <= disp_d;
      sign_q    <= sign_d;
      show_q    <= show_d;
      busy_q    <= busy_d;
      upd_q     <= upd_d;
    end
  end

  assign bus.ScoreToShow = disp_q;
  assign bus.SignToShow  = sign_q;
  assign bus.ShowSign    = show_q;
  assign bus.busy        = busy_q;
  assign bus.updated     = upd_q;
  assign bus.saturated   = (score_q == MAX_S) || (score_q == MIN_S);
endmodule
